// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared widths, mem-op field layout, size codes and FSM state type for
//   the memory-access stage (mem_access) and its lane aligner (mem_align).
//   mem-op field: {mem, store, unsigned, size[1:0]}; size 00=B 01=H 10=W.
//   Optional feature macro used by mem_access: MEM_MISALIGN_TRAP_EN.
package mem_access_pkg;

   localparam int WORD    = 32;
   localparam int W_RD    = 5;
   localparam int W_MEMOP = 5;

   // Bit positions inside the mem-op field
   localparam int MOP_MEM   = 4;
   localparam int MOP_STORE = 3;
   localparam int MOP_UNS   = 2;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      MA_IDLE = 2'd0,
      MA_REQ  = 2'd1,
      MA_WAIT = 2'd2,
      MA_DONE = 2'd3
   } ma_state_e;

   // Halfword must be 2-byte aligned; word (and the unused 11 code) 4-byte.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

   // Clears the low address bits that a halfword/word access cannot use.
   function automatic logic [WORD-1:0] force_align(input logic [1:0] size, input logic [WORD-1:0] addr);
      case (size)
         SZ_B:    return addr;
         SZ_H:    return {addr[WORD-1:1], 1'b0};
         default: return {addr[WORD-1:2], 2'b00};
      endcase
   endfunction

endpackage

// File: rtl/mem_access_align.sv
// mem_align
//   Combinational lane logic for the memory-access stage.
//   Store side: byte enables and lane-replicated write data.
//   Load side: extracts byte/half/word from the returned word and extends.
// Ports
//   i_size     [1:0]   access size (00=B 01=H 10=W)
//   i_uns              1 = zero-extend loads
//   i_off      [1:0]   byte offset within the word (addr[1:0])
//   i_st_data  [WORD]  raw store data
//   i_rdata    [WORD]  load data from memory
//   o_be       [3:0]   store byte enables
//   o_wdata    [WORD]  replicated store data
//   o_ld_data  [WORD]  aligned, extended load data
module mem_align
   import mem_access_pkg::*;
(
   input  logic [1:0]      i_size,
   input  logic            i_uns,
   input  logic [1:0]      i_off,
   input  logic [WORD-1:0] i_st_data,
   input  logic [WORD-1:0] i_rdata,
   output logic [3:0]      o_be,
   output logic [WORD-1:0] o_wdata,
   output logic [WORD-1:0] o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      o_be    = 4'b1111;
      o_wdata = i_st_data;
      case (i_size)
         SZ_B: begin
            o_be    = 4'b0001 << i_off;
            o_wdata = {4{i_st_data[7:0]}};
         end
         SZ_H: begin
            o_be    = 4'b0011 << {i_off[1], 1'b0};
            o_wdata = {2{i_st_data[15:0]}};
         end
         default: begin
            o_be    = 4'b1111;
            o_wdata = i_st_data;
         end
      endcase
   end

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_off)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

      o_ld_data = i_rdata;
      case (i_size)
         SZ_B:    o_ld_data = {{24{~i_uns & w_byte[7]}}, w_byte};
         SZ_H:    o_ld_data = {{16{~i_uns & w_half[15]}}, w_half};
         default: o_ld_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// mem_access
//   Memory-access pipeline stage between EX and writeback. Takes one EX
//   result per v_i/stall_o handshake; non-memory ops reach writeback one
//   cycle later, loads/stores run a req/gnt/rvalid transaction first.
//   Optional macro MEM_MISALIGN_TRAP_EN: misaligned H/W ops bypass memory
//   and return exc_o=1 with the address as data. Without it exc_o stays 0
//   and misaligned addresses are forced aligned.
// Ports
//   clk, rst (sync, active-low)
//   EX side : v_i, stall_o, wb_i, rd_num_i, alu_data_i, st_data_i, memop_i
//   WB side : v_o, stall_i, wb_o, rd_num_o, rd_data_o, exc_o
//   Memory  : dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
//             dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
module mem_access
   import mem_access_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               v_i,
   output logic               stall_o,
   input  logic               wb_i,
   input  logic [W_RD-1:0]    rd_num_i,
   input  logic [WORD-1:0]    alu_data_i,
   input  logic [WORD-1:0]    st_data_i,
   input  logic [W_MEMOP-1:0] memop_i,
   output logic               v_o,
   input  logic               stall_i,
   output logic               wb_o,
   output logic [W_RD-1:0]    rd_num_o,
   output logic [WORD-1:0]    rd_data_o,
   output logic               exc_o,
   output logic               dmem_req_o,
   output logic               dmem_we_o,
   output logic [WORD-1:0]    dmem_addr_o,
   output logic [3:0]         dmem_be_o,
   output logic [WORD-1:0]    dmem_wdata_o,
   input  logic               dmem_gnt_i,
   input  logic               dmem_rvalid_i,
   input  logic [WORD-1:0]    dmem_rdata_i
);

   ma_state_e r_state, w_state_nxt;

   // In-flight memory op
   logic [WORD-1:0] r_addr;
   logic [WORD-1:0] r_st_data;
   logic            r_store;
   logic            r_uns;
   logic [1:0]      r_size;
   logic [W_RD-1:0] r_rd;
   logic            r_wb;
   logic [WORD-1:0] r_ld_data;

   // Result register toward writeback
   logic            r_v_o;
   logic            r_wb_o;
   logic [W_RD-1:0] r_rd_o;
   logic [WORD-1:0] r_data_o;
   logic            r_exc_o;

   logic            w_out_free;
   logic            w_accept;
   logic            w_is_mem;
   logic            w_trap;
   logic [WORD-1:0] w_addr_eff;
   logic [WORD-1:0] w_ld_data;

   assign w_out_free = ~(r_v_o & stall_i);
   assign stall_o    = (r_state != MA_IDLE) | ~w_out_free;
   assign w_accept   = v_i & ~stall_o;
   assign w_is_mem   = memop_i[MOP_MEM];

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_trap     = w_is_mem & is_misaligned(memop_i[1:0], alu_data_i[1:0]);
   assign w_addr_eff = alu_data_i;
`else
   assign w_trap     = 1'b0;
   assign w_addr_eff = force_align(memop_i[1:0], alu_data_i);
`endif

   mem_align u_align (
      .i_size    (r_size),
      .i_uns     (r_uns),
      .i_off     (r_addr[1:0]),
      .i_st_data (r_st_data),
      .i_rdata   (dmem_rdata_i),
      .o_be      (dmem_be_o),
      .o_wdata   (dmem_wdata_o),
      .o_ld_data (w_ld_data)
   );

   assign dmem_we_o   = r_store;
   assign dmem_addr_o = {r_addr[WORD-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (!rst) r_state <= MA_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      dmem_req_o  = 1'b0;
      case (r_state)
         MA_IDLE: if (w_accept && w_is_mem && !w_trap) w_state_nxt = MA_REQ;
         MA_REQ: begin
            dmem_req_o = 1'b1;
            if (dmem_gnt_i) w_state_nxt = r_store ? MA_DONE : MA_WAIT;
         end
         MA_WAIT: if (dmem_rvalid_i) w_state_nxt = MA_DONE;
         MA_DONE: if (w_out_free) w_state_nxt = MA_IDLE;
         default: w_state_nxt = MA_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_addr    <= '0;
         r_st_data <= '0;
         r_store   <= 1'b0;
         r_uns     <= 1'b0;
         r_size    <= SZ_B;
         r_rd      <= '0;
         r_wb      <= 1'b0;
         r_ld_data <= '0;
      end else begin
         if (r_state == MA_IDLE && w_accept && w_is_mem && !w_trap) begin
            r_addr    <= w_addr_eff;
            r_st_data <= st_data_i;
            r_store   <= memop_i[MOP_STORE];
            r_uns     <= memop_i[MOP_UNS];
            r_size    <= memop_i[1:0];
            r_rd      <= rd_num_i;
            r_wb      <= wb_i;
            r_ld_data <= '0;
         end
         if (r_state == MA_WAIT && dmem_rvalid_i) r_ld_data <= w_ld_data;
      end
   end

   // Advances only when writeback is not holding the current result; a
   // pass-through op and a DONE result can never coincide since EX is
   // stalled whenever the FSM is away from IDLE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_v_o    <= 1'b0;
         r_wb_o   <= 1'b0;
         r_rd_o   <= '0;
         r_data_o <= '0;
         r_exc_o  <= 1'b0;
      end else if (w_out_free) begin
         r_v_o   <= 1'b0;
         r_wb_o  <= 1'b0;
         r_exc_o <= 1'b0;
         if (r_state == MA_IDLE && w_accept && (!w_is_mem || w_trap)) begin
            r_v_o    <= 1'b1;
            r_wb_o   <= wb_i & ~w_trap;
            r_rd_o   <= rd_num_i;
            r_data_o <= alu_data_i;
            r_exc_o  <= w_trap;
         end else if (r_state == MA_DONE) begin
            r_v_o    <= 1'b1;
            r_wb_o   <= r_wb & ~r_store;
            r_rd_o   <= r_rd;
            r_data_o <= r_ld_data;
         end
      end
   end

   assign v_o       = r_v_o;
   assign wb_o      = r_wb_o;
   assign rd_num_o  = r_rd_o;
   assign rd_data_o = r_data_o;
   assign exc_o     = r_exc_o;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
//   Directed bench for mem_access: pass-through, loads/stores of every size,
//   delayed grant/rvalid, writeback stall and reset mid-transaction.
//   Define MEM_MISALIGN_TRAP_EN at build time to exercise the trap variant.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        v_i = 1'b0;
   logic        stall_o;
   logic        wb_i = 1'b0;
   logic [4:0]  rd_num_i = '0;
   logic [31:0] alu_data_i = '0;
   logic [31:0] st_data_i = '0;
   logic [4:0]  memop_i = '0;
   logic        v_o;
   logic        stall_i = 1'b0;
   logic        wb_o;
   logic [4:0]  rd_num_o;
   logic [31:0] rd_data_o;
   logic        exc_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_gnt_i = 1'b0;
   logic        dmem_rvalid_i = 1'b0;
   logic [31:0] dmem_rdata_i = '0;

   int n_pass  = 0;
   int n_total = 0;

   mem_access dut (
      .clk           (clk),
      .rst           (rst),
      .v_i           (v_i),
      .stall_o       (stall_o),
      .wb_i          (wb_i),
      .rd_num_i      (rd_num_i),
      .alu_data_i    (alu_data_i),
      .st_data_i     (st_data_i),
      .memop_i       (memop_i),
      .v_o           (v_o),
      .stall_i       (stall_i),
      .wb_o          (wb_o),
      .rd_num_o      (rd_num_o),
      .rd_data_o     (rd_data_o),
      .exc_o         (exc_o),
      .dmem_req_o    (dmem_req_o),
      .dmem_we_o     (dmem_we_o),
      .dmem_addr_o   (dmem_addr_o),
      .dmem_be_o     (dmem_be_o),
      .dmem_wdata_o  (dmem_wdata_o),
      .dmem_gnt_i    (dmem_gnt_i),
      .dmem_rvalid_i (dmem_rvalid_i),
      .dmem_rdata_i  (dmem_rdata_i)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One memory op from accept to the single v_o pulse.
   task automatic mem_txn(input string tag, input logic [31:0] addr, input logic [31:0] st,
                          input logic [4:0] op, input logic [4:0] rd, input logic wb,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic exp_wb,
                          input logic [31:0] exp_data);
      int   cyc;
      int   n;
      int   exp_lat;
      logic hold_ok;
      logic stall_ok;
      exp_lat = op[3] ? 3 + gnt_dly : 4 + gnt_dly + rv_dly;
      v_i = 1'b1; wb_i = wb; rd_num_i = rd; alu_data_i = addr; st_data_i = st; memop_i = op;
      tick();
      v_i = 1'b0;
      cyc = 1; hold_ok = 1'b1; stall_ok = 1'b1;
      chk({tag, ".req"}, dmem_req_o, 1'b1);
      chk({tag, ".we"}, dmem_we_o, op[3]);
      chk({tag, ".addr"}, dmem_addr_o, exp_addr);
      if (op[3]) begin
         chk({tag, ".be"}, dmem_be_o, exp_be);
         chk({tag, ".wdata"}, dmem_wdata_o, exp_wdata);
      end
      repeat (gnt_dly) begin
         if (dmem_req_o !== 1'b1 || dmem_addr_o !== exp_addr || stall_o !== 1'b1 || v_o !== 1'b0)
            hold_ok = 1'b0;
         tick(); cyc++;
      end
      if (dmem_req_o !== 1'b1 || dmem_addr_o !== exp_addr) hold_ok = 1'b0;
      dmem_gnt_i = 1'b1;
      tick(); cyc++;
      dmem_gnt_i = 1'b0;
      chk({tag, ".req_hold"}, hold_ok, 1'b1);
      if (!op[3]) begin
         repeat (rv_dly) begin
            if (stall_o !== 1'b1 || dmem_req_o !== 1'b0 || v_o !== 1'b0) stall_ok = 1'b0;
            tick(); cyc++;
         end
         dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
         tick(); cyc++;
         dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      end
      n = 0;
      while (v_o !== 1'b1 && n < 20) begin
         if (stall_o !== 1'b1) stall_ok = 1'b0;
         tick(); cyc++; n++;
      end
      chk({tag, ".v_o_seen"}, v_o, 1'b1);
      chk({tag, ".stall"}, stall_ok, 1'b1);
      chk({tag, ".latency"}, cyc, exp_lat);
      chk({tag, ".wb_o"}, wb_o, exp_wb);
      chk({tag, ".rd_num_o"}, rd_num_o, rd);
      chk({tag, ".exc_o"}, exc_o, 1'b0);
      if (!op[3]) chk({tag, ".rd_data_o"}, rd_data_o, exp_data);
      tick();
      chk({tag, ".single_v_o"}, v_o, 1'b0);
   endtask

   initial begin
      // Reset
      rst = 1'b0;
      tick(); tick();
      chk("rst.v_o", v_o, 1'b0);
      chk("rst.wb_o", wb_o, 1'b0);
      chk("rst.exc_o", exc_o, 1'b0);
      chk("rst.req", dmem_req_o, 1'b0);
      chk("rst.rd_num_o", rd_num_o, 5'd0);
      chk("rst.rd_data_o", rd_data_o, 32'h0);
      chk("rst.stall_o", stall_o, 1'b0);
      rst = 1'b1;
      tick();

      // ALU pass-through
      v_i = 1'b1; memop_i = 5'b00000; alu_data_i = 32'h1234; rd_num_i = 5'd5; wb_i = 1'b1;
      tick();
      v_i = 1'b0;
      chk("alu.v_o", v_o, 1'b1);
      chk("alu.wb_o", wb_o, 1'b1);
      chk("alu.rd_num_o", rd_num_o, 5'd5);
      chk("alu.rd_data_o", rd_data_o, 32'h1234);
      chk("alu.req", dmem_req_o, 1'b0);
      tick();
      chk("alu.v_o_drop", v_o, 1'b0);

      //       tag    addr          st            op        rd  wb gd rd rdata         exp_addr      be       wdata         ewb  data
      mem_txn("lb",   32'h103,      32'h0,        5'b10000, 3,  1, 0, 0, 32'h80FFFF7F, 32'h100,      4'b0000, 32'h0,        1'b1, 32'hFFFFFF80);
      mem_txn("lbu",  32'h103,      32'h0,        5'b10100, 4,  1, 0, 0, 32'h80FFFF7F, 32'h100,      4'b0000, 32'h0,        1'b1, 32'h00000080);
      mem_txn("sh",   32'h202,      32'h0000ABCD, 5'b11001, 7,  1, 0, 0, 32'h0,        32'h200,      4'b1100, 32'hABCDABCD, 1'b0, 32'h0);
      mem_txn("lw_d", 32'h300,      32'h0,        5'b10010, 8,  1, 3, 2, 32'hDEADBEEF, 32'h300,      4'b0000, 32'h0,        1'b1, 32'hDEADBEEF);
      mem_txn("lh",   32'h102,      32'h0,        5'b10001, 9,  1, 0, 0, 32'h80011234, 32'h100,      4'b0000, 32'h0,        1'b1, 32'hFFFF8001);
      mem_txn("lhu",  32'h100,      32'h0,        5'b10101, 10, 1, 0, 1, 32'h0000F00F, 32'h100,      4'b0000, 32'h0,        1'b1, 32'h0000F00F);
      mem_txn("sb",   32'h101,      32'h1234565A, 5'b11000, 2,  1, 1, 0, 32'h0,        32'h100,      4'b0010, 32'h5A5A5A5A, 1'b0, 32'h0);
      mem_txn("sw",   32'h404,      32'h12345678, 5'b11010, 6,  1, 0, 0, 32'h0,        32'h404,      4'b1111, 32'h12345678, 1'b0, 32'h0);
      mem_txn("lb0",  32'h104,      32'h0,        5'b10000, 12, 1, 0, 0, 32'hAABBCC7F, 32'h104,      4'b0000, 32'h0,        1'b1, 32'h0000007F);

`ifdef MEM_MISALIGN_TRAP_EN
      v_i = 1'b1; memop_i = 5'b10010; alu_data_i = 32'h101; rd_num_i = 5'd9; wb_i = 1'b1;
      tick();
      v_i = 1'b0;
      chk("trap.req", dmem_req_o, 1'b0);
      chk("trap.v_o", v_o, 1'b1);
      chk("trap.exc_o", exc_o, 1'b1);
      chk("trap.wb_o", wb_o, 1'b0);
      chk("trap.rd_data_o", rd_data_o, 32'h101);
      tick();
      chk("trap.v_o_drop", v_o, 1'b0);
`else
      mem_txn("sh_mis", 32'h203,    32'h0000BEEF, 5'b11001, 13, 1, 0, 0, 32'h0,        32'h200,      4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0);
      mem_txn("lw_mis", 32'h101,    32'h0,        5'b10010, 14, 1, 0, 0, 32'hCAFEF00D, 32'h100,      4'b0000, 32'h0,        1'b1, 32'hCAFEF00D);
`endif

      // Writeback stall while a load result is produced
      stall_i = 1'b1;
      v_i = 1'b1; memop_i = 5'b10010; alu_data_i = 32'h500; rd_num_i = 5'd11; wb_i = 1'b1;
      tick();
      v_i = 1'b0;
      dmem_gnt_i = 1'b1;
      tick();
      dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BADF00D;
      tick();
      dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      tick();
      // Offer an ALU op; it must wait until writeback releases.
      v_i = 1'b1; memop_i = 5'b00000; alu_data_i = 32'h77; rd_num_i = 5'd12; wb_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("stl.v_o[%0d]", i), v_o, 1'b1);
         chk($sformatf("stl.data[%0d]", i), rd_data_o, 32'h0BADF00D);
         chk($sformatf("stl.stall_o[%0d]", i), stall_o, 1'b1);
         tick();
      end
      chk("stl.rd_num_o", rd_num_o, 5'd11);
      stall_i = 1'b0;
      tick();
      v_i = 1'b0;
      chk("stl.next_v_o", v_o, 1'b1);
      chk("stl.next_data", rd_data_o, 32'h77);
      chk("stl.next_rd", rd_num_o, 5'd12);
      tick();
      chk("stl.drop", v_o, 1'b0);

      // Reset while waiting for load data, then a stray rvalid
      v_i = 1'b1; memop_i = 5'b10010; alu_data_i = 32'h600; rd_num_i = 5'd15; wb_i = 1'b1;
      tick();
      v_i = 1'b0;
      dmem_gnt_i = 1'b1;
      tick();
      dmem_gnt_i = 1'b0;
      chk("rstw.in_wait_stall", stall_o, 1'b1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rstw.req", dmem_req_o, 1'b0);
      chk("rstw.v_o", v_o, 1'b0);
      chk("rstw.stall_o", stall_o, 1'b0);
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
      tick();
      dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      chk("rstw.stray_v_o", v_o, 1'b0);
      chk("rstw.stray_req", dmem_req_o, 1'b0);
      chk("rstw.stray_stall", stall_o, 1'b0);
      tick();
      chk("rstw.late_v_o", v_o, 1'b0);
      v_i = 1'b1; memop_i = 5'b00000; alu_data_i = 32'h99; rd_num_i = 5'd1; wb_i = 1'b0;
      tick();
      v_i = 1'b0;
      chk("rstw.alu_v_o", v_o, 1'b1);
      chk("rstw.alu_data", rd_data_o, 32'h99);
      chk("rstw.alu_wb", wb_o, 1'b0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
